// File: rtl/i2c_master.sv
// i2c_master
// Single-transaction I2C master: one register write (START, addr+W, reg,
// data, STOP) or one register read (START, addr+R, reg, data with master
// NACK, STOP). There is no repeated START: the read direction is sent in the
// first address byte and the slave returns the byte selected by reg_addr.
//
// Every bus bit is four quarters Q0..Q3, each quarter QDIV system clocks long.
// scl is low in Q0/Q1 and high in Q2/Q3. sda is only changed on entry to Q0.
// It is sampled on entry to Q3. The START and STOP edges are the exceptions.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 transfer request, only looked at while idle
//   rw                    0 = write, 1 = read (latched with start)
//   dev_addr[6:0]         7-bit slave address (latched with start)
//   reg_addr[7:0]         slave register address (latched with start)
//   wdata[7:0]            byte to write (latched with start)
//   rdata[7:0]            last byte read, only updated by a successful read
//   busy                  transfer in progress
//   done                  one-clock pulse when a transfer ends (ok or NACK)
//   ack_err               slave NACKed; held until the next accepted start
//   scl                   push-pull I2C clock (no clock stretching)
//   sda                   open-drain data: driven low or released to z

module i2c_master #(
    parameter int QDIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int DW = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, RDATA, MNACK, STOP
    } state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic [6:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          rw_l;
    logic [6:0]    dev_l;
    logic [7:0]    reg_l;
    logic [7:0]    wdata_l;
    logic          sda_low;
    logic          sda_smp;
    logic          tick;

    // Open-drain output: the only values ever put on the wire are 0 and z.
    assign sda  = sda_low ? 1'b0 : 1'bz;

    // tick marks the last system clock of the current quarter.
    assign tick = (div == DW'(QDIV - 1));

    // Whole controller in one block. Bit-level work happens on quarter
    // boundaries: Q2 entry raises scl, Q3 entry samples sda, and the end of
    // Q3 (next bit's Q0 entry) drops scl and puts the next bit on sda.
    // tx_sh holds only the bits still to be sent after the one on the wire,
    // so the bit for the coming Q0 is always tx_sh[6].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div     <= '0;
            qtr     <= 2'd0;
            bit_cnt <= 3'd0;
            tx_sh   <= 7'd0;
            rx_sh   <= 8'd0;
            rw_l    <= 1'b0;
            dev_l   <= 7'd0;
            reg_l   <= 8'd0;
            wdata_l <= 8'd0;
            sda_low <= 1'b0;
            sda_smp <= 1'b1;
            scl     <= 1'b1;
            rdata   <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                div <= '0;
                qtr <= 2'd0;
                if (start) begin
                    rw_l    <= rw;
                    dev_l   <= dev_addr;
                    reg_l   <= reg_addr;
                    wdata_l <= wdata;
                    ack_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= START;
                end
            end else begin
                div <= tick ? '0 : div + DW'(1);

                // STOP: sda goes high one clock after scl rose, still inside Q2,
                // so the STOP edge never coincides with the scl edge.
                if (state == STOP && qtr == 2'd2 && div == '0) begin
                    sda_low <= 1'b0;
                end

                if (tick) begin
                    qtr <= qtr + 2'd1;
                    case (qtr)
                        2'd1: begin
                            scl <= 1'b1;
                            if (state == START) begin
                                sda_low <= 1'b1;
                            end
                        end
                        2'd2: begin
                            sda_smp <= sda;
                            if (state == RDATA) begin
                                rx_sh <= {rx_sh[6:0], sda};
                            end
                        end
                        2'd3: begin
                            scl <= 1'b0;
                            case (state)
                                START: begin
                                    state   <= ADDR;
                                    bit_cnt <= 3'd7;
                                    tx_sh   <= {dev_l[5:0], rw_l};
                                    sda_low <= ~dev_l[6];
                                end
                                ADDR, REG, WDATA: begin
                                    if (bit_cnt == 3'd0) begin
                                        sda_low <= 1'b0;
                                        if (state == ADDR) begin
                                            state <= ACK_A;
                                        end else if (state == REG) begin
                                            state <= ACK_R;
                                        end else begin
                                            state <= ACK_W;
                                        end
                                    end else begin
                                        bit_cnt <= bit_cnt - 3'd1;
                                        tx_sh   <= {tx_sh[5:0], 1'b0};
                                        sda_low <= ~tx_sh[6];
                                    end
                                end
                                ACK_A: begin
                                    if (sda_smp) begin
                                        ack_err <= 1'b1;
                                        state   <= STOP;
                                        sda_low <= 1'b1;
                                    end else begin
                                        state   <= REG;
                                        bit_cnt <= 3'd7;
                                        tx_sh   <= reg_l[6:0];
                                        sda_low <= ~reg_l[7];
                                    end
                                end
                                ACK_R: begin
                                    if (sda_smp) begin
                                        ack_err <= 1'b1;
                                        state   <= STOP;
                                        sda_low <= 1'b1;
                                    end else if (rw_l) begin
                                        state   <= RDATA;
                                        bit_cnt <= 3'd7;
                                        sda_low <= 1'b0;
                                    end else begin
                                        state   <= WDATA;
                                        bit_cnt <= 3'd7;
                                        tx_sh   <= wdata_l[6:0];
                                        sda_low <= ~wdata_l[7];
                                    end
                                end
                                ACK_W: begin
                                    ack_err <= sda_smp;
                                    state   <= STOP;
                                    sda_low <= 1'b1;
                                end
                                RDATA: begin
                                    if (bit_cnt == 3'd0) begin
                                        state <= MNACK;
                                    end else begin
                                        bit_cnt <= bit_cnt - 3'd1;
                                    end
                                end
                                MNACK: begin
                                    rdata   <= rx_sh;
                                    state   <= STOP;
                                    sda_low <= 1'b1;
                                end
                                STOP: begin
                                    scl   <= 1'b1;
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                                default: begin
                                    state <= IDLE;
                                end
                            endcase
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master
// Directed bench for i2c_master with QDIV=4. A clock-sampled slave model at
// address 0x66 ACKs and serves reads from a small memory. Expected bus frames
// ({byte, ack bit}) and expected transfer results are queued when stimulus is
// issued. A monitor pops and compares them as the bus and done present them,
// and it also checks START/STOP placement and scl high/low times.

module tb_i2c_master;

    localparam int QDIV      = 4;
    localparam int XFER_CLKS = 29 * 4 * QDIV;
    localparam int NACK_CLKS = 11 * 4 * QDIV;
    localparam logic [6:0] SLV_ADDR = 7'h66;

    typedef struct {
        logic       ack_err;
        logic [7:0] rdata;
        int         cycles;
    } done_exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start    = 1'b0;
    logic       rw       = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wdata    = 8'd0;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    wire        sda;
    logic       slv_drive = 1'b0;

    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    i2c_master #(.QDIV(QDIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda      (sda)
    );

    always #5 clk = ~clk;

    logic [8:0] exp_frames[$];
    done_exp_t  exp_done[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         start_cyc = 0;
    int         done_cnt  = 0;
    logic [7:0] mem [256];

    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_done = 1'b0;
    logic       cur_scl, cur_sda;
    logic       in_xfer = 1'b0, stop_seen = 1'b0, addressed = 1'b0, srw = 1'b0;
    logic       have_rise = 1'b0, have_fall = 1'b0;
    int         fbit = 0, idx = 0, rise_t = 0, fall_t = 0, dur = 0;
    logic [7:0] sh = 8'd0, regp = 8'd0, rd_byte = 8'd0;
    done_exp_t  got;

    // Free-running clock counter used for transfer and scl timing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one transfer request and queue the expected done result.
    task automatic applyStimulus(input logic t_rw, input logic [6:0] t_dev,
                                 input logic [7:0] t_reg, input logic [7:0] t_wd,
                                 input logic want_done, input logic e_err,
                                 input logic [7:0] e_rdata, input int e_cycles);
        done_exp_t e;
        @(negedge clk);
        rw       = t_rw;
        dev_addr = t_dev;
        reg_addr = t_reg;
        wdata    = t_wd;
        start    = 1'b1;
        if (want_done) begin
            e.ack_err = e_err;
            e.rdata   = e_rdata;
            e.cycles  = e_cycles;
            exp_done.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_done.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: %0d transfers pending, required 0", name, exp_done.size());
            exp_done.delete();
            exp_frames.delete();
        end
    endtask

    // Bus monitor, slave model and scoreboard checker, all sampled on the
    // falling system clock so scl/sda edges from one posedge are seen together.
    // START/STOP are sda edges with scl high in two consecutive samples.
    always @(negedge clk) begin
        cur_scl = scl;
        cur_sda = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (!rst_n) begin
            slv_drive = 1'b0;
            in_xfer   = 1'b0;
            stop_seen = 1'b0;
            addressed = 1'b0;
            have_rise = 1'b0;
            have_fall = 1'b0;
            fbit      = 0;
            idx       = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_scl && cur_scl && (prev_sda != cur_sda)) begin
                if (!cur_sda) begin
                    checkOutput("start_on_idle_bus", {31'd0, in_xfer}, 32'd0);
                    in_xfer   = 1'b1;
                    fbit      = 0;
                    idx       = 0;
                    addressed = 1'b0;
                    have_rise = 1'b0;
                    have_fall = 1'b0;
                    stop_seen = 1'b0;
                end else begin
                    checkOutput("stop_position", in_xfer ? fbit : -1, 32'd1);
                    in_xfer   = 1'b0;
                    stop_seen = 1'b1;
                    slv_drive = 1'b0;
                end
            end

            if (prev_scl && !cur_scl) begin
                if (have_rise) checkOutput("scl_high_clks", cyc - rise_t, 2 * QDIV);
                fall_t    = cyc;
                have_fall = 1'b1;
                if (in_xfer) begin
                    if (fbit == 8) begin
                        case (idx)
                            0: begin
                                addressed = (sh[7:1] == SLV_ADDR);
                                srw       = sh[0];
                                slv_drive = addressed;
                            end
                            1: begin
                                regp      = sh;
                                slv_drive = addressed;
                            end
                            default: begin
                                if (!srw) begin
                                    if (addressed) mem[regp] = sh;
                                    slv_drive = addressed;
                                end else begin
                                    slv_drive = 1'b0;
                                end
                            end
                        endcase
                    end else if (fbit == 9) begin
                        fbit = 0;
                        idx++;
                        if (idx == 2 && srw && addressed) begin
                            rd_byte   = mem[regp];
                            slv_drive = !rd_byte[7];
                        end else begin
                            slv_drive = 1'b0;
                        end
                    end else if (idx == 2 && srw && addressed && fbit < 8) begin
                        slv_drive = !rd_byte[7 - fbit];
                    end else begin
                        slv_drive = 1'b0;
                    end
                end
            end

            if (!prev_scl && cur_scl) begin
                if (have_fall) checkOutput("scl_low_clks", cyc - fall_t, 2 * QDIV);
                rise_t    = cyc;
                have_rise = 1'b1;
                if (in_xfer) begin
                    if (fbit < 8) begin
                        sh = {sh[6:0], cur_sda};
                    end else if (fbit == 8) begin
                        if (exp_frames.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("[TB] FAIL unexpected_frame: got 0x%0h, required none", {sh, cur_sda});
                        end else begin
                            checkOutput("bus_frame", {23'd0, sh, cur_sda}, {23'd0, exp_frames.pop_front()});
                        end
                    end
                    fbit++;
                end
            end

            if (prev_done) checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got a done pulse, required none");
                end else begin
                    got = exp_done.pop_front();
                    checkOutput("ack_err", {31'd0, ack_err}, {31'd0, got.ack_err});
                    checkOutput("rdata", {24'd0, rdata}, {24'd0, got.rdata});
                    dur = cyc - start_cyc;
                    n_tests++;
                    if (dur < got.cycles - 2 || dur > got.cycles + 2) begin
                        n_fail++;
                        $display("[TB] FAIL duration: got %0d clks, required %0d +/-2", dur, got.cycles);
                    end
                    checkOutput("stop_seen", {31'd0, stop_seen}, 32'd1);
                    checkOutput("frames_left", exp_frames.size(), 32'd0);
                    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
                end
                done_cnt++;
                stop_seen = 1'b0;
            end
            prev_done = done;
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    // Directed sequence: reset, write, read, address NACK, reset in REG,
    // write after reset, and a start pulse ignored while busy.
    initial begin
        int n;
        int done_before;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_scl", {31'd0, scl}, 32'd1);
        checkOutput("reset_sda", {31'd0, sda}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_rdata", {24'd0, rdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] write 0x66 reg 0x12 <= 0xA5");
        exp_frames.push_back(9'h198);
        exp_frames.push_back(9'h024);
        exp_frames.push_back(9'h14A);
        applyStimulus(1'b0, 7'h66, 8'h12, 8'hA5, 1'b1, 1'b0, 8'h00, XFER_CLKS);
        waitDone("write");
        checkOutput("slave_mem_12", {24'd0, mem[8'h12]}, 32'hA5);

        $display("[TB] read 0x66 reg 0x12");
        mem[8'h12] = 8'h3C;
        exp_frames.push_back(9'h19A);
        exp_frames.push_back(9'h024);
        exp_frames.push_back(9'h079);
        applyStimulus(1'b1, 7'h66, 8'h12, 8'h00, 1'b1, 1'b0, 8'h3C, XFER_CLKS);
        waitDone("read");

        $display("[TB] write to absent device 0x55");
        exp_frames.push_back(9'h155);
        applyStimulus(1'b0, 7'h55, 8'h12, 8'h77, 1'b1, 1'b1, 8'h3C, NACK_CLKS);
        waitDone("nack");
        repeat (10) @(negedge clk);
        checkOutput("ack_err_held", {31'd0, ack_err}, 32'd1);

        $display("[TB] reset during register byte");
        exp_frames.push_back(9'h198);
        applyStimulus(1'b0, 7'h66, 8'h12, 8'hA5, 1'b0, 1'b0, 8'h00, XFER_CLKS);
        n = 0;
        while (!(idx == 1 && fbit == 2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_reg_byte", {31'd0, (idx == 1 && fbit == 2)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_scl", {31'd0, scl}, 32'd1);
        checkOutput("midreset_sda", {31'd0, sda}, 32'd1);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_rdata", {24'd0, rdata}, 32'd0);
        checkOutput("frames_left_at_reset", exp_frames.size(), 32'd0);
        exp_frames.delete();
        exp_done.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] write 0x66 reg 0x34 <= 0x5A after reset");
        exp_frames.push_back(9'h198);
        exp_frames.push_back(9'h068);
        exp_frames.push_back(9'h0B4);
        applyStimulus(1'b0, 7'h66, 8'h34, 8'h5A, 1'b1, 1'b0, 8'h00, XFER_CLKS);
        waitDone("write_after_reset");
        checkOutput("slave_mem_34", {24'd0, mem[8'h34]}, 32'h5A);

        $display("[TB] start pulse while busy");
        done_before = done_cnt;
        exp_frames.push_back(9'h198);
        exp_frames.push_back(9'h040);
        exp_frames.push_back(9'h102);
        applyStimulus(1'b0, 7'h66, 8'h20, 8'h81, 1'b1, 1'b0, 8'h00, XFER_CLKS);
        n = 0;
        while (!(idx == 2 && fbit == 3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_data_byte", {31'd0, (idx == 2 && fbit == 3)}, 32'd1);
        rw       = 1'b1;
        dev_addr = 7'h55;
        reg_addr = 8'hFF;
        wdata    = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("busy_start");
        repeat (520) @(negedge clk);
        checkOutput("single_done", done_cnt - done_before, 32'd1);
        checkOutput("idle_after_ignored_start", {31'd0, busy}, 32'd0);
        checkOutput("slave_mem_20", {24'd0, mem[8'h20]}, 32'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
